// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
//   Bundles the MEM-stage load/store request and response signals between the
//   pipeline (master) and the data memory responder (slave).
//
//   Request  (master -> slave): MemRead, MemWrite, Datatype[1:0], Address[31:0],
//                               WriteData[31:0]; held stable while Stall=1.
//   Response (slave -> master): ReadData[31:0] (registered load result),
//                               Stall (combinational hold request),
//                               AlignErr (registered misalignment flag).
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Datatype;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AlignErr;

    modport master (
        output MemRead, MemWrite, Datatype, Address, WriteData,
        input  ReadData, Stall, AlignErr
    );

    modport slave (
        input  MemRead, MemWrite, Datatype, Address, WriteData,
        output ReadData, Stall, AlignErr
    );
endinterface

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   MEM-stage data memory responder. Services word/half/byte loads and stores
//   against an internal word-organised synchronous RAM (big-endian lanes),
//   doing read-modify-write for sub-word stores and flagging misaligned
//   accesses. Stall holds the pipeline until each access reaches RESP.
//
//   Ports:
//     Clk  - system clock, rising edge
//     Rst  - asynchronous, active-low reset
//     bus  - slave side of data_mem_responder_if (request in, response out)
//
//   Parameters:
//     DEPTH_WORDS - number of 32-bit RAM words (power of 2)
//     IDX_W       - log2(DEPTH_WORDS); word index = Address[IDX_W+1:2]
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                 Clk,
    input  logic                 Rst,
    data_mem_responder_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_RMW_WR = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             align_err_q, align_err_d;
    logic [31:0]      merged_q, merged_d;
    logic [31:0]      ram_rdata_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             ram_we;
    logic [31:0]      ram_wdata;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             is_word, is_half, req, misaligned;
    logic [4:0]       byte_shift, half_shift;
    logic [7:0]       byte_field;
    logic [15:0]      half_field;
    logic [31:0]      load_field, merged_word, lane_mask, lane_data;
    logic             unused_addr;

    // Address bits above the index are ignored, so the RAM wraps.
    assign idx         = bus.Address[IDX_W+1:2];
    assign off         = bus.Address[1:0];
    assign unused_addr = ^bus.Address[31:IDX_W+2];

    assign is_half    = (bus.Datatype == 2'b01);
    assign is_word    = (bus.Datatype == 2'b00) || (bus.Datatype == 2'b11);
    assign req        = bus.MemRead | bus.MemWrite;
    assign misaligned = (is_half && off[0]) || (is_word && (off != 2'b00));

    // Big-endian lanes: offset 0 is the most significant byte/half.
    assign byte_shift = {~off, 3'b000};
    assign half_shift = {~off[1], 4'b0000};
    assign byte_field = 8'(ram_rdata_q >> byte_shift);
    assign half_field = 16'(ram_rdata_q >> half_shift);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        load_field = ram_rdata_q;
        lane_mask  = 32'h0000_00FF << byte_shift;
        lane_data  = {24'h0, bus.WriteData[7:0]} << byte_shift;
        if (is_half) begin
            load_field = {{16{half_field[15]}}, half_field};
            lane_mask  = 32'h0000_FFFF << half_shift;
            lane_data  = {16'h0, bus.WriteData[15:0]} << half_shift;
        end else if (!is_word) begin
            load_field = {{24{byte_field[7]}}, byte_field};
        end
    end

    assign merged_word = (ram_rdata_q & ~lane_mask) | lane_data;

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        align_err_d = align_err_q;
        merged_d    = merged_q;
        ram_we      = 1'b0;
        ram_wdata   = bus.WriteData;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        align_err_d = 1'b1;
                        read_data_d = 32'h0;
                        state_d     = S_RESP;
                    end else if (bus.MemWrite) begin
                        if (is_word) begin
                            ram_we  = 1'b1;
                            state_d = S_RESP;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                read_data_d = load_field;
                state_d     = S_RESP;
            end
            S_RMW_RD: begin
                merged_d = merged_word;
                state_d  = S_RMW_WR;
            end
            S_RMW_WR: begin
                ram_we    = 1'b1;
                ram_wdata = merged_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                align_err_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            read_data_q <= 32'h0;
            align_err_q <= 1'b0;
            merged_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            align_err_q <= align_err_d;
            merged_q    <= merged_d;
        end
    end

    // NOTE: the RAM array and its read register have no reset so they map
    // onto block RAM; contents are undefined until written.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            mem[idx] <= ram_wdata;
        end
        ram_rdata_q <= mem[idx];
    end

    assign bus.Stall    = ((state_q == S_IDLE) && req) ||
                          (state_q == S_RD) || (state_q == S_RMW_RD) ||
                          (state_q == S_RMW_WR);
    assign bus.ReadData = read_data_q;
    assign bus.AlignErr = align_err_q;

endmodule
